// File: rtl/mvm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mvm_sequencer                                              |
// | Description : Run/busy sequencer for one matrix-vector pass. Reads the   |
// |               K/R header from the input and weight SRAMs, streams K      |
// |               operand pairs per row to the MAC datapath, and writes each |
// |               returned row result to the output SRAM.                    |
// |               Optional: define MVM_SEQ_PERF_EN to add perf_cycles, a     |
// |               32-bit count of busy cycles for the most recent pass.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mvm_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int MAX_K  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic [DATA_W-1:0] mac_in_data,
  output logic [DATA_W-1:0] mac_w_data,
  input  logic              acc_valid,
  input  logic [DATA_W-1:0] acc_data,
  output logic              cfg_error
`ifdef MVM_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  // Number of words in one SRAM; the whole weight matrix plus header must fit.
  localparam int                  DEPTH   = 1 << ADDR_W;
  localparam logic [DATA_W-1:0]   K_LIMIT = DATA_W'(MAX_K);
  localparam logic [DATA_W-1:0]   R_LIMIT = DATA_W'(DEPTH);
  localparam logic [2*DATA_W-1:0] P_LIMIT = (2*DATA_W)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_HDR_LAT = 3'd2,
    S_CHECK   = 3'd3,
    S_STREAM  = 3'd4,
    S_WAIT    = 3'd5,
    S_WRITE   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   k_len_q, k_len_d;
  logic [DATA_W-1:0]   r_len_q, r_len_d;
  logic [DATA_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0]   r_q, r_d;

  // Header legality: header word 0 plus R*K weights must fit, i.e. R*K <= DEPTH-1.
  logic [2*DATA_W-1:0] prod;
  logic                cfg_bad;
  logic                k_last;
  logic                r_last;

  assign prod    = {{DATA_W{1'b0}}, r_len_q} * {{DATA_W{1'b0}}, k_len_q};
  assign cfg_bad = (k_len_q == '0) || (r_len_q == '0) || (k_len_q > K_LIMIT) ||
                   (r_len_q > R_LIMIT) || (prod > P_LIMIT);
  assign k_last  = (k_q == k_len_q - DATA_W'(1));
  assign r_last  = (r_q == r_len_q - DATA_W'(1));

  // Next-state and registered-output computation for the pass sequencer.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cfg_err_d = cfg_err_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    valid_d   = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    k_len_d   = k_len_q;
    r_len_d   = r_len_q;
    k_d       = k_q;
    r_d       = r_q;
    case (state_q)
      S_IDLE: begin
        if (dut_run) begin
          state_d   = S_HDR;
          busy_d    = 1'b1;
          cfg_err_d = 1'b0;
          in_addr_d = '0;
          w_addr_d  = '0;
        end
      end
      S_HDR: begin
        state_d = S_HDR_LAT;
      end
      S_HDR_LAT: begin
        k_len_d = sram_dut_read_data;
        r_len_d = wmem_dut_read_data;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          r_d       = '0;
          k_d       = '0;
          in_addr_d = ADDR_W'(1);
          w_addr_d  = ADDR_W'(1);
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        // Flags are registered so they line up with the SRAM read data.
        valid_d   = 1'b1;
        first_d   = (k_q == '0);
        last_d    = k_last;
        in_addr_d = in_addr_q + ADDR_W'(1);
        // Weight pointer runs straight on into the next row's first weight.
        w_addr_d  = w_addr_q + ADDR_W'(1);
        if (k_last) begin
          state_d = S_WAIT;
        end else begin
          k_d = k_q + DATA_W'(1);
        end
      end
      S_WAIT: begin
        if (acc_valid) begin
          we_d      = 1'b1;
          wr_addr_d = r_q[ADDR_W-1:0];
          wr_data_d = acc_data;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_last) begin
          state_d = S_DONE;
        end else begin
          r_d       = r_q + DATA_W'(1);
          k_d       = '0;
          in_addr_d = ADDR_W'(1);
          state_d   = S_STREAM;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any pass in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      k_len_q   <= '0;
      r_len_q   <= '0;
      k_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      k_len_q   <= k_len_d;
      r_len_q   <= r_len_d;
      k_q       <= k_d;
      r_q       <= r_d;
    end
  end

  assign dut_busy               = busy_q;
  assign cfg_error              = cfg_err_q;
  assign dut_sram_read_address  = in_addr_q;
  assign dut_wmem_read_address  = w_addr_q;
  assign dut_sram_write_enable  = we_q;
  assign dut_sram_write_address = wr_addr_q;
  assign dut_sram_write_data    = wr_data_q;
  assign mac_valid              = valid_q;
  assign mac_first              = first_q;
  assign mac_last               = last_q;
  assign mac_in_data            = sram_dut_read_data;
  assign mac_w_data             = wmem_dut_read_data;

`ifdef MVM_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: cleared on pass acceptance, holds once the pass ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && dut_run) begin
      perf_q <= '0;
    end else if (busy_q) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mvm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mvm_sequencer                                           |
// | Description : Self-checking bench for mvm_sequencer with SRAM and MAC    |
// |               datapath models and a table of hand-computed passes.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mvm_sequencer;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int MAX_K  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [DATA_W-1:0] wmem_dut_read_data;
  logic              dut_sram_write_enable;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              mac_valid;
  logic              mac_first;
  logic              mac_last;
  logic [DATA_W-1:0] mac_in_data;
  logic [DATA_W-1:0] mac_w_data;
  logic              acc_valid;
  logic [DATA_W-1:0] acc_data;
  logic              cfg_error;
`ifdef MVM_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  always #5 clk = ~clk;

  mvm_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_K (MAX_K)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .dut_sram_read_address (dut_sram_read_address),
    .sram_dut_read_data    (sram_dut_read_data),
    .dut_wmem_read_address (dut_wmem_read_address),
    .wmem_dut_read_data    (wmem_dut_read_data),
    .dut_sram_write_enable (dut_sram_write_enable),
    .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_data   (dut_sram_write_data),
    .mac_valid             (mac_valid),
    .mac_first             (mac_first),
    .mac_last              (mac_last),
    .mac_in_data           (mac_in_data),
    .mac_w_data            (mac_w_data),
    .acc_valid             (acc_valid),
    .acc_data              (acc_data),
    .cfg_error             (cfg_error)
`ifdef MVM_SEQ_PERF_EN
    ,
    .perf_cycles           (perf_cycles)
`endif
  );

  // Input and weight SRAMs: one-cycle registered read.
  logic [15:0] imem [0:4095];
  logic [15:0] wmem [0:4095];

  // Registered read ports of the two source SRAMs.
  always @(posedge clk) begin
    sram_dut_read_data <= imem[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
  end

  // MAC datapath model: result latency lat_sel (0 or 2) after mac_last.
  int          lat_sel;
  logic [15:0] acc_r, pd1, pd2;
  logic        pv1, pv2;
  logic [15:0] row_res;

  assign row_res   = (mac_first ? 16'd0 : acc_r) + mac_in_data * mac_w_data;
  assign acc_valid = (lat_sel == 0) ? (mac_valid && mac_last) : pv2;
  assign acc_data  = (lat_sel == 0) ? row_res : pd2;

  // Accumulator and two-stage result pipeline of the datapath model.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= '0; pd1 <= '0; pd2 <= '0; pv1 <= 1'b0; pv2 <= 1'b0;
    end else begin
      if (mac_valid) acc_r <= row_res;
      pv1 <= mac_valid && mac_last;
      pd1 <= row_res;
      pv2 <= pv1;
      pd2 <= pd1;
    end
  end

  typedef struct {
    int k; int r; int lat; int err; int busy; int valids; int writes;
    int e0; int e1; int e2; int la; int ld;
  } vec_t;

  vec_t vecs [11];

  int n_cmp, n_bad;
  int busy_cnt, valid_cnt, wr_cnt, seq_err, row_idx, cur_k;
  int wa [3];
  int wd [3];
  int lwa, lwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d", name, act, act, exp);
    end
  endtask

  task automatic clear_mon();
    busy_cnt = 0; valid_cnt = 0; wr_cnt = 0; seq_err = 0; row_idx = 0;
    lwa = -1; lwd = -1;
    for (int i = 0; i < 3; i++) begin wa[i] = -1; wd[i] = -1; end
  endtask

  // Advance to the next falling edge and record what the DUT showed this cycle.
  task automatic tick();
    @(negedge clk);
    if (dut_busy === 1'b1) busy_cnt++;
    if (mac_valid === 1'b1) begin
      valid_cnt++;
      if (mac_first !== (row_idx == 0)) seq_err++;
      if (mac_last !== (row_idx == cur_k - 1)) seq_err++;
      row_idx = (mac_last === 1'b1) ? 0 : row_idx + 1;
    end
    if (dut_sram_write_enable === 1'b1) begin
      if (wr_cnt < 3) begin
        wa[wr_cnt] = int'(dut_sram_write_address);
        wd[wr_cnt] = int'(dut_sram_write_data);
      end
      lwa = int'(dut_sram_write_address);
      lwd = int'(dut_sram_write_data);
      wr_cnt++;
    end
  endtask

  task automatic load(input int k, input int r);
    imem[0] = 16'(k);
    wmem[0] = 16'(r);
    for (int i = 0; i < k && i < 4095; i++) imem[1 + i] = 16'(i + 1);
    for (int j = 0; j < r * k && j < 4095; j++) wmem[1 + j] = 16'(j + 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     32'(dut_busy), 0);
    chk({tag, "_rd_addr"},  32'(dut_sram_read_address), 0);
    chk({tag, "_w_addr"},   32'(dut_wmem_read_address), 0);
    chk({tag, "_we"},       32'(dut_sram_write_enable), 0);
    chk({tag, "_wr_addr"},  32'(dut_sram_write_address), 0);
    chk({tag, "_wr_data"},  32'(dut_sram_write_data), 0);
    chk({tag, "_valid"},    32'(mac_valid), 0);
    chk({tag, "_first"},    32'(mac_first), 0);
    chk({tag, "_last"},     32'(mac_last), 0);
    chk({tag, "_cfg_err"},  32'(cfg_error), 0);
  endtask

  task automatic start(input int k, input int r, input int lat);
    load(k, r);
    lat_sel = lat;
    cur_k   = k;
    clear_mon();
    dut_run = 1'b1;
    tick();
    dut_run = 1'b0;
    chk("accept_busy", 32'(dut_busy), 1);
    chk("accept_cfg_clear", 32'(cfg_error), 0);
  endtask

  // Wait for busy to drop; poke_at >= 0 pulses dut_run at that cycle.
  task automatic wait_idle(input int budget, input int poke_at);
    int n;
    n = 0;
    while (dut_busy === 1'b1 && n < budget) begin
      if (poke_at >= 0) dut_run = (n == poke_at);
      tick();
      n++;
    end
    if (poke_at >= 0) dut_run = 1'b0;
    chk("pass_done_in_budget", 32'(dut_busy), 0);
  endtask

  task automatic check_vec(input int idx);
    vec_t v;
    int   e [3];
    v = vecs[idx];
    e[0] = v.e0; e[1] = v.e1; e[2] = v.e2;
    chk($sformatf("v%0d_cfg_error", idx), 32'(cfg_error), 32'(v.err));
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'(v.busy));
    chk($sformatf("v%0d_mac_valids", idx), 32'(valid_cnt), 32'(v.valids));
    chk($sformatf("v%0d_writes", idx), 32'(wr_cnt), 32'(v.writes));
    chk($sformatf("v%0d_first_last_seq", idx), 32'(seq_err), 0);
    for (int i = 0; i < 3; i++) begin
      if (i < v.writes) begin
        chk($sformatf("v%0d_wr%0d_addr", idx, i), 32'(wa[i]), 32'(i));
        chk($sformatf("v%0d_wr%0d_data", idx, i), 32'(wd[i]), 32'(e[i]));
      end
    end
    if (v.writes > 0) begin
      chk($sformatf("v%0d_last_addr", idx), 32'(lwa), 32'(v.la));
      chk($sformatf("v%0d_last_data", idx), 32'(lwd), 32'(v.ld));
    end
  endtask

  task automatic run_vec(input int idx, input int poke_at);
    start(vecs[idx].k, vecs[idx].r, vecs[idx].lat);
    wait_idle(vecs[idx].busy + 50, poke_at);
    check_vec(idx);
  endtask

  initial begin
    int n;
    //           k    r     lat err busy   valids writes e0     e1  e2   la    ld
    vecs[0]  = '{4,   3,    2,  0,  28,    12,    3,     30,    70, 110, 2,    110};
    vecs[1]  = '{1,   1,    2,  0,  9,     1,     1,     1,     0,  0,   0,    1};
    vecs[2]  = '{0,   3,    2,  1,  4,     0,     0,     0,     0,  0,   0,    0};
    vecs[3]  = '{3,   0,    2,  1,  4,     0,     0,     0,     0,  0,   0,    0};
    vecs[4]  = '{257, 1,    2,  1,  4,     0,     0,     0,     0,  0,   0,    0};
    vecs[5]  = '{64,  64,   2,  1,  4,     0,     0,     0,     0,  0,   0,    0};
    vecs[6]  = '{2,   2,    0,  0,  12,    4,     2,     5,     11, 0,   1,    11};
    vecs[7]  = '{256, 1,    2,  0,  264,   256,   1,     54656, 0,  0,   0,    54656};
    vecs[8]  = '{1,   4095, 2,  0,  20479, 4095,  4095,  1,     2,  3,   4094, 4095};
    vecs[9]  = '{3,   4097, 2,  1,  4,     0,     0,     0,     0,  0,   0,    0};
    vecs[10] = '{4,   3,    0,  0,  22,    12,    3,     30,    70, 110, 2,    110};

    n_cmp = 0; n_bad = 0; cur_k = 1; lat_sel = 2;
    clear_mon();
    reset   = 1'b1;
    dut_run = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i, -1);

    // dut_run pulsed mid-pass must not disturb or extend the pass.
    run_vec(0, 5);

    // Reset during the stream of row 1 aborts the pass at once.
    start(4, 3, 2);
    n = 0;
    while (wr_cnt < 1 && n < 100) begin tick(); n++; end
    chk("rst_row0_written", 32'(wr_cnt), 1);
    tick();
    tick();
    chk("rst_in_stream", 32'(mac_valid), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_only_one_write", 32'(wr_cnt), 1);
    chk("rst_write_addr", 32'(wa[0]), 0);
    chk("rst_write_data", 32'(wd[0]), 30);
    run_vec(0, -1);

    // dut_run held across DONE starts a second identical pass straight away.
    load(4, 3);
    lat_sel = 2;
    cur_k   = 4;
    clear_mon();
    dut_run = 1'b1;
    tick();
    wait_idle(100, -1);
    chk("b2b_first_busy", 32'(busy_cnt), 28);
    chk("b2b_first_writes", 32'(wr_cnt), 3);
    clear_mon();
    tick();
    dut_run = 1'b0;
    chk("b2b_restart", 32'(dut_busy), 1);
    wait_idle(100, -1);
    check_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvm_sequencer.md
Name: mvm_sequencer

Overview:
- Run/busy controller that sequences one matrix-vector pass of the MAC datapath over the three 12-bit x 16-bit SRAMs (input, weight, output).
- Reads a header from the input and weight SRAMs, then streams operand pairs to the MAC datapath row by row.
- Writes each returned 16-bit row result to the output SRAM.
- Sits between the top-level run/busy handshake and the MAC/accumulate datapath.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM data width.
- MAX_K, 256, largest legal vector length; a larger header value is a config error.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dut_run  in  1  start request, sampled in IDLE only.
- dut_busy  out  1  high while a pass is in progress.
- dut_sram_read_address  out  ADDR_W  input-SRAM read address.
- sram_dut_read_data  in  DATA_W  input-SRAM data, valid 1 cycle after address.
- dut_wmem_read_address  out  ADDR_W  weight-SRAM read address.
- wmem_dut_read_data  in  DATA_W  weight-SRAM data, valid 1 cycle after address.
- dut_sram_write_enable  out  1  output-SRAM write strobe.
- dut_sram_write_address  out  ADDR_W  output-SRAM write address.
- dut_sram_write_data  out  DATA_W  output-SRAM write data.
- mac_valid  out  1  operand pair valid this cycle.
- mac_first  out  1  first pair of a row; datapath clears its accumulator.
- mac_last  out  1  last pair of a row.
- mac_in_data  out  DATA_W  equals sram_dut_read_data (combinational pass-through).
- mac_w_data  out  DATA_W  equals wmem_dut_read_data (combinational pass-through).
- acc_valid  in  1  single-cycle pulse: row result ready.
- acc_data  in  DATA_W  row result, already quantised.
- cfg_error  out  1  sticky for the pass: header was illegal.

Behaviour:
- Reset values: dut_busy=0, all addresses=0, dut_sram_write_enable=0, write data=0, mac_valid/first/last=0, cfg_error=0, FSM=IDLE.
- Reset asserted mid-pass aborts the pass immediately. No further writes occur.
- FSM states and transitions:
  - IDLE: dut_run=1 -> HDR. dut_busy rises on the next edge.
  - HDR: drive read address 0 on both SRAMs -> HDR_LAT.
  - HDR_LAT: capture K=sram_dut_read_data and R=wmem_dut_read_data -> CHECK.
  - CHECK: K==0, R==0, K>MAX_K, R>4096 or 1+R*K>4096 sets cfg_error -> DONE; otherwise r=0 -> STREAM.
  - STREAM: for k=0..K-1, one pair per cycle with no bubbles.
    - Input address = 1+k.
    - Weight address = 1+r*K+k, kept as a running pointer with no multiplier.
    - mac_valid, mac_first (k==0) and mac_last (k==K-1) are registered so they align with SRAM data one cycle later.
    - After the last address -> WAIT.
  - WAIT: hold until acc_valid=1; capture acc_data -> WRITE.
    - acc_valid outside WAIT is ignored.
    - There is no timeout.
  - WRITE: one cycle with write_enable=1, write_address=r, write_data=captured value. If r==R-1 -> DONE; else r++ -> STREAM.
  - DONE: dut_busy=0 on the next edge -> IDLE.
- cfg_error is cleared on the next accepted dut_run.
- dut_run held high across DONE starts a new pass immediately from IDLE.
- dut_run while busy is ignored.
- acc_valid arriving in the same cycle as the final mac_last pair is legal and is taken in WAIT's first cycle.
- Nominal latency: 3 + R*(K+1+L+1) + 1 cycles, where L is the datapath result latency after mac_last.

Optional Feature:
- MVM_SEQ_PERF_EN defined: adds output perf_cycles (32 bits).
  - Cleared when a pass is accepted.
  - Increments each cycle dut_busy=1.
  - Holds after DONE.
- Undefined: the port and counter are absent; nothing else changes.

Test Plan:
- K=4, R=3, inputs 1..4, weights 1..12, datapath L=2:
  - 12 mac_valid pulses in 3 bursts of 4.
  - Outputs at addresses 0..2 = 30, 70, 110.
  - dut_busy low after DONE.
- K=1, R=1:
  - mac_first and mac_last asserted together.
  - Exactly one write, to address 0.
- K=0 or R=0 -> cfg_error=1, no mac_valid, no writes, dut_busy high for 4 cycles.
- K=MAX_K+1 -> cfg_error=1. K=64, R=64 (1+R*K=4097) -> cfg_error=1.
- Reset asserted during the STREAM of row 1 of the K=4/R=3 case:
  - All outputs return to reset values asynchronously.
  - Only address 0 has been written.
  - A fresh dut_run completes normally.
- dut_run pulsed while busy -> ignored. A back-to-back dut_run after DONE -> second pass completes with identical results.
